// File: rtl/eq_run_defs.sv
// Shared definitions for the equal-pair run stimulus generator.
// State codes are Gray-ordered IDLE -> RUN -> BRK; the unused code 2'b10 recovers to IDLE.
package eq_run_defs;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_BRK  = 2'b11
  } state_t;

  localparam state_t ST_DEFAULT = ST_IDLE;

endpackage

// File: rtl/eq_run_tracker.sv
// Predicts the output of an equal-run detector: counts consecutive equal valid pairs
// and registers whether the count has reached MATCH_LEN.
module eq_run_tracker #(
  parameter int MATCH_LEN = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic A,
  input  logic B,
  input  logic pair_valid,
  output logic expect_out
);

  localparam int CW = $clog2(MATCH_LEN + 1);
  localparam logic [CW-1:0] SAT = CW'(MATCH_LEN);

  logic [CW-1:0] r_eqCnt;
  logic [CW-1:0] w_nextCnt;
  logic          r_expect;

  // Any idle cycle or unequal pair breaks the run; the count saturates so it never wraps.
  always_comb begin
    w_nextCnt = '0;
    if (pair_valid && (A == B)) begin
      w_nextCnt = (r_eqCnt == SAT) ? SAT : r_eqCnt + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_eqCnt  <= '0;
      r_expect <= 1'b0;
    end else begin
      r_eqCnt  <= w_nextCnt;
      r_expect <= (w_nextCnt >= SAT);
    end
  end

  assign expect_out = r_expect;

endmodule

// File: rtl/eq_run_gen.sv
// Command-driven A/B pair stream generator: L equal pairs then one break pair,
// with a registered prediction of the downstream equal-run detector output.
module eq_run_gen
  import eq_run_defs::*;
#(
  parameter int CNT_W     = 4,
  parameter int MATCH_LEN = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_len,
  input  logic             cmd_lvl,
  input  logic             cmd_toggle,
  output logic             A,
  output logic             B,
  output logic             pair_valid,
  output logic             done,
  output logic             expect_out
);

  state_t           r_state;
  state_t           w_nextState;
  logic [CNT_W-1:0] r_rem;
  logic [CNT_W-1:0] w_nextRem;
  logic             r_cur;
  logic             w_nextCur;
  logic             r_toggle;
  logic             w_nextToggle;
  logic             r_A;
  logic             r_B;
  logic             r_pairValid;
  logic             r_done;
  logic             w_nextA;
  logic             w_nextB;
  logic             w_nextPairValid;
  logic             w_nextDone;

  // The outputs are registered, so this block decides what the next cycle emits.
  // r_cur always holds the value of the next pair in sequence, which is also the
  // A value of the break pair once the run is exhausted.
  always_comb begin
    w_nextState     = r_state;
    w_nextRem       = r_rem;
    w_nextCur       = r_cur;
    w_nextToggle    = r_toggle;
    w_nextA         = 1'b0;
    w_nextB         = 1'b0;
    w_nextPairValid = 1'b0;
    w_nextDone      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (cmd_valid) begin
          w_nextToggle    = cmd_toggle;
          w_nextA         = cmd_lvl;
          w_nextPairValid = 1'b1;
          if (cmd_len != '0) begin
            w_nextState = ST_RUN;
            w_nextRem   = cmd_len;
            w_nextB     = cmd_lvl;
            w_nextCur   = cmd_toggle ? ~cmd_lvl : cmd_lvl;
          end else begin
            w_nextState = ST_BRK;
            w_nextB     = ~cmd_lvl;
            w_nextDone  = 1'b1;
            w_nextCur   = cmd_lvl;
          end
        end
      end
      ST_RUN: begin
        w_nextPairValid = 1'b1;
        w_nextA         = r_cur;
        if (r_rem == CNT_W'(1)) begin
          w_nextState = ST_BRK;
          w_nextB     = ~r_cur;
          w_nextDone  = 1'b1;
        end else begin
          w_nextB   = r_cur;
          w_nextRem = r_rem - CNT_W'(1);
          w_nextCur = r_toggle ? ~r_cur : r_cur;
        end
      end
      ST_BRK: begin
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_DEFAULT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_rem       <= '0;
      r_cur       <= 1'b0;
      r_toggle    <= 1'b0;
      r_A         <= 1'b0;
      r_B         <= 1'b0;
      r_pairValid <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_nextState;
      r_rem       <= w_nextRem;
      r_cur       <= w_nextCur;
      r_toggle    <= w_nextToggle;
      r_A         <= w_nextA;
      r_B         <= w_nextB;
      r_pairValid <= w_nextPairValid;
      r_done      <= w_nextDone;
    end
  end

  assign cmd_ready  = (r_state == ST_IDLE);
  assign A          = r_A;
  assign B          = r_B;
  assign pair_valid = r_pairValid;
  assign done       = r_done;

  eq_run_tracker #(
    .MATCH_LEN(MATCH_LEN)
  ) u_tracker (
    .clk       (clk),
    .reset     (reset),
    .A         (r_A),
    .B         (r_B),
    .pair_valid(r_pairValid),
    .expect_out(expect_out)
  );

endmodule
